vga_timing_gen: RTL
===================

# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA output path. Runs on `vga_clk` (25 MHz pixel clock) and produces horizontal/vertical sync, the active-video flag `blank`, and the pixel coordinates `DrawX`/`DrawY`. These coordinates feed the sprite/palette renderers directly downstream, which register colour one cycle after sampling them. Also provides a per-frame start pulse and a frame counter for animation and beat-sequencer UI timing.

## Interface

Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- Derived totals: `H_TOTAL` = 800, `V_TOTAL` = 525.

Ports:
- `vga_clk` input 1: pixel clock; single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `hs` output 1: horizontal sync, active low.
- `vs` output 1: vertical sync, active low.
- `blank` output 1: 1 = active video (pixel drawable), 0 = blanking.
- `DrawX` output 10: current horizontal count, 0..H_TOTAL-1.
- `DrawY` output 10: current vertical count, 0..V_TOTAL-1.
- `frame_start` output 1: one-cycle pulse, high while (DrawX, DrawY) = (0, 0).
- `frame_count` output 16: number of frames begun since reset, minus one.

## Operation

- All outputs are driven directly from flops. There are no combinational output paths.
- Horizontal counter `hc` increments every cycle and wraps from H_TOTAL-1 to 0.
- Vertical counter `vc` increments only when `hc` wraps, and wraps from V_TOTAL-1 to 0.
- `DrawX` = `hc` and `DrawY` = `vc`, including during blanking. They are never clamped.
- `hs`, `vs`, `blank` and `frame_start` are registered decodes of the *next* counter values, so they are cycle-aligned with `DrawX`/`DrawY`:
  - `hs` = 0 iff H_VISIBLE+H_FRONT ≤ DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - `vs` = 0 iff V_VISIBLE+V_FRONT ≤ DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
  - `blank` = 1 iff DrawX < 640 and DrawY < 480.
  - `frame_start` = 1 iff DrawX = 0 and DrawY = 0.
- `frame_count` increments, wrapping modulo 2^16, on the same edge that asserts `frame_start`.
- Counter arithmetic is 10-bit unsigned. The comparisons must not overflow for the default parameters.
- Reset (sampled high on a `vga_clk` edge) loads:
  - `hc` = 799, `vc` = 524
  - `hs` = 1, `vs` = 1, `blank` = 0, `frame_start` = 0
  - `frame_count` = 16'hFFFF
- Reset has priority over counting. Asserting reset mid-frame abandons the frame immediately, with no partial sync pulse carried over.

## Timing

- First edge with `reset` low: DrawX = 0, DrawY = 0, `blank` = 1, `frame_start` = 1, `frame_count` = 0.
- Line period is 800 cycles with an hsync low time of 96 cycles. Frame period is 420000 cycles, with a vsync low time of 1600 cycles (lines 490–491, all columns).
- Downstream renderers sample `DrawX`/`DrawY`/`blank` and present colour one cycle later. Sync alignment for that latency is covered under Configuration.
- If reset is held for N cycles, outputs stay at their reset values for all N cycles.

## Configuration

- `VGA_SYNC_ALIGN_EN` defined:
  - `hs` and `vs` pass through one additional register stage, lagging `DrawX`/`DrawY` by exactly 1 cycle. This matches the one-cycle colour register in the renderers.
  - The extra stage resets to 1.
  - `blank`, `DrawX`, `DrawY`, `frame_start` and `frame_count` are unaffected.
- Macro undefined: `hs`/`vs` are aligned with `DrawX`/`DrawY` as described in Operation.

## Test plan

- Reset: hold `reset` for 3 cycles. Check DrawX = 799, DrawY = 524, hs = vs = 1, blank = 0, frame_count = FFFF. On release, the next cycle shows (0,0), blank = 1, frame_start = 1, frame_count = 0.
- Horizontal timing: over one line, `hs` falls at DrawX = 656 and rises at DrawX = 752. `blank` falls at DrawX = 640 and rises at DrawX = 0 for DrawY < 480.
- Vertical timing: `vs` is low exactly for DrawY ∈ {490, 491}, i.e. 1600 cycles. `blank` stays 0 for every pixel with DrawY ≥ 480.
- Wrap and counter: run 3 full frames. `frame_start` pulses exactly every 420000 cycles and `frame_count` reads 0, 1, 2. DrawY steps 524 → 0 on the same cycle DrawX steps 799 → 0.
- Mid-frame reset: assert `reset` at (300, 200) during hsync-inactive, and again at DrawX = 700 with hs = 0. In both cases the next cycle shows hs = 1 and the reset values, and counting restarts from (0,0).
- With `VGA_SYNC_ALIGN_EN`: `hs` falls on the cycle DrawX = 657 and `vs` falls at DrawX = 1, DrawY = 490. `blank` timing is identical to the undefined build.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel/line counters, registered sync/blank decodes, frame pulse and count.
// Define VGA_SYNC_ALIGN_EN to delay hs/vs one cycle, matching the renderers' colour register.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_start,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_STOP  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_STOP  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hc_next;
    logic [9:0] vc_next;
    logic       hs_next;
    logic       vs_next;
    logic       blank_next;
    logic       fs_next;
    logic       hs_p0;
    logic       vs_p0;

    // Decode the values the counters are about to take so registered flags line up with DrawX/DrawY
    always_comb begin
        hc_next = DrawX + 10'd1;
        vc_next = DrawY;
        if (DrawX == H_LAST) begin
            hc_next = '0;
            vc_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
        end
        hs_next    = !((hc_next >= HS_START) && (hc_next < HS_STOP));
        vs_next    = !((vc_next >= VS_START) && (vc_next < VS_STOP));
        blank_next = (hc_next < H_VIS) && (vc_next < V_VIS);
        fs_next    = (hc_next == '0) && (vc_next == '0);
    end

    // Stage p0: counters plus registered decodes
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            hs_p0       <= 1'b1;
            vs_p0       <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 16'hFFFF;
        end else begin
            DrawX       <= hc_next;
            DrawY       <= vc_next;
            hs_p0       <= hs_next;
            vs_p0       <= vs_next;
            blank       <= blank_next;
            frame_start <= fs_next;
            if (fs_next) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    // Stage p1: syncs lag the coordinates by one cycle
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs <= 1'b1;
            vs <= 1'b1;
        end else begin
            hs <= hs_p0;
            vs <= vs_p0;
        end
    end
`else
    assign hs = hs_p0;
    assign vs = vs_p0;
`endif

endmodule
